// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo_ram port arbiter.
// The arbiter mode records which direction was served last.
package fifo_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int OUTBUF_DEPTH       = 2;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } mode_e;

endpackage

// File: rtl/fifo_arb_outbuf.sv
// Two-entry output buffer that absorbs fifo_ram read data ahead of the consumer.
// Pushes come from completed RAM reads. Pops come from the consumer handshake.
module fifo_arb_outbuf
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [OUTBUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [OUTBUF_DEPTH];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != 2'd0);

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OUTBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign valid = (count_q != 2'd0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_port_arbiter.sv
// Shares the single-ported fifo_ram between two byte writers and one reader.
// Read latency is hidden behind a small output buffer, and a burst limit prevents either side from starving the other.
module fifo_port_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr0_valid,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_ready,
    input  logic                  wr1_valid,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    output logic                  fifo_write,
    output logic                  fifo_read,
    output logic                  fifo_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_full,
    input  logic                  fifo_empty
);

    localparam int BW = (BURST_MAX > 2) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX - 1);

    mode_e           mode_q, mode_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            rr_last_q, rr_last_d;
    logic            inflight_q, inflight_d;

    logic [1:0]      buf_cnt;
    logic            buf_valid;
    logic [DATA_WIDTH-1:0] buf_head;

    logic            can_wr, can_rd;
    logic            serve_wr, serve_rd;
    logic            pick_wr1;
    mode_e           dir;

    always_comb begin
        can_wr     = (wr0_valid || wr1_valid) && !fifo_full;
        // Credit for a read is taken before the consumer pops, so the buffer can never overflow.
        can_rd     = !fifo_empty && (({1'b0, buf_cnt} + {2'b00, inflight_q}) < 3'd2);
        serve_wr   = 1'b0;
        serve_rd   = 1'b0;
        pick_wr1   = wr1_valid && (!wr0_valid || !rr_last_q);
        dir        = mode_q;
        mode_d     = mode_q;
        burst_d    = burst_q;
        rr_last_d  = rr_last_q;
        inflight_d = 1'b0;

        if (can_wr && can_rd) begin
            if (burst_q < BURST_LIMIT) begin
                serve_wr = (mode_q == MODE_WRITE);
            end else begin
                serve_wr = (mode_q == MODE_READ);
            end
            serve_rd = !serve_wr;
        end else begin
            serve_wr = can_wr;
            serve_rd = can_rd;
        end

        serve_wr = serve_wr && reset;
        serve_rd = serve_rd && reset;

        if (serve_wr || serve_rd) begin
            dir    = serve_wr ? MODE_WRITE : MODE_READ;
            mode_d = dir;
            if (dir != mode_q) begin
                burst_d = '0;
            end else if (burst_q != BURST_LIMIT) begin
                burst_d = burst_q + 1'b1;
            end
        end
        if (serve_wr) begin
            rr_last_d = pick_wr1;
        end
        inflight_d = serve_rd;

        fifo_write   = serve_wr;
        fifo_read    = serve_rd;
        fifo_enable  = serve_wr || serve_rd;
        fifo_data_in = serve_wr ? (pick_wr1 ? wr1_data : wr0_data) : '0;
        wr0_ready    = serve_wr && !pick_wr1;
        wr1_ready    = serve_wr && pick_wr1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q     <= MODE_READ;
            burst_q    <= '0;
            rr_last_q  <= 1'b1;
            inflight_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            burst_q    <= burst_d;
            rr_last_q  <= rr_last_d;
            inflight_q <= inflight_d;
        end
    end

    fifo_arb_outbuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outbuf (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (rd_ready),
        .count     (buf_cnt),
        .valid     (buf_valid),
        .head      (buf_head)
    );

    assign rd_valid = buf_valid;
    assign rd_data  = buf_head;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter driving a behavioural 16-deep fifo_ram model.
// Expected grant sequences are worked out by hand from the arbitration rules.
module tb_fifo_port_arbiter;

    logic       clock;
    logic       reset;
    logic       wr0_valid, wr1_valid;
    logic [7:0] wr0_data, wr1_data;
    logic       wr0_ready, wr1_ready;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic [7:0] fifo_data_in, fifo_data_out;
    logic       fifo_write, fifo_read, fifo_enable;
    logic       fifo_full, fifo_empty;

    logic       ram_flush, ram_preload;
    logic [7:0] ram_mem [16];
    logic [4:0] ram_count;
    logic [3:0] ram_wp, ram_rp;

    int checks   = 0;
    int failures = 0;

    fifo_port_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .wr0_valid     (wr0_valid),
        .wr0_data      (wr0_data),
        .wr0_ready     (wr0_ready),
        .wr1_valid     (wr1_valid),
        .wr1_data      (wr1_data),
        .wr1_ready     (wr1_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .fifo_data_in  (fifo_data_in),
        .fifo_write    (fifo_write),
        .fifo_read     (fifo_read),
        .fifo_enable   (fifo_enable),
        .fifo_data_out (fifo_data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural fifo_ram: registered read data, one operation per enabled cycle.
    always @(posedge clock) begin
        if (ram_flush) begin
            ram_count <= 5'd0;
            ram_wp    <= 4'd0;
            ram_rp    <= 4'd0;
            if (ram_preload) begin
                for (int i = 0; i < 8; i++) begin
                    ram_mem[i] <= 8'h80 + 8'(i);
                end
                ram_wp    <= 4'd8;
                ram_count <= 5'd8;
            end
        end else if (fifo_enable) begin
            if (fifo_write && ram_count != 5'd16) begin
                ram_mem[ram_wp] <= fifo_data_in;
                ram_wp          <= ram_wp + 4'd1;
                ram_count       <= ram_count + 5'd1;
            end else if (fifo_read && ram_count != 5'd0) begin
                fifo_data_out <= ram_mem[ram_rp];
                ram_rp        <= ram_rp + 4'd1;
                ram_count     <= ram_count - 5'd1;
            end
        end
    end

    assign fifo_full  = (ram_count == 5'd16);
    assign fifo_empty = (ram_count == 5'd0);

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic w0v, input logic [7:0] w0d,
                                 input logic w1v, input logic [7:0] w1d, input logic rr,
                                 input logic flush, input logic preload);
        @(negedge clock);
        reset       = rst;
        wr0_valid   = w0v;
        wr0_data    = w0d;
        wr1_valid   = w1v;
        wr1_data    = w1d;
        rd_ready    = rr;
        ram_flush   = flush;
        ram_preload = preload;
        #1;
    endtask

    // Grant codes: 0 idle, 1 write from wr0, 2 write from wr1, 3 read.
    task automatic checkGrant(input string tag, input int code, input logic [7:0] exp_data);
        checkOutput({tag, "_wr0_ready"}, 32'(wr0_ready), 32'(code == 1));
        checkOutput({tag, "_wr1_ready"}, 32'(wr1_ready), 32'(code == 2));
        checkOutput({tag, "_fifo_write"}, 32'(fifo_write), 32'(code == 1 || code == 2));
        checkOutput({tag, "_fifo_read"}, 32'(fifo_read), 32'(code == 3));
        checkOutput({tag, "_fifo_enable"}, 32'(fifo_enable), 32'(code != 0));
        if (code == 1 || code == 2) begin
            checkOutput({tag, "_data_in"}, 32'(fifo_data_in), 32'(exp_data));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wr0_ready"}, 32'(wr0_ready), 32'd0);
        checkOutput({tag, "_wr1_ready"}, 32'(wr1_ready), 32'd0);
        checkOutput({tag, "_fifo_write"}, 32'(fifo_write), 32'd0);
        checkOutput({tag, "_fifo_read"}, 32'(fifo_read), 32'd0);
        checkOutput({tag, "_fifo_enable"}, 32'(fifo_enable), 32'd0);
        checkOutput({tag, "_data_in"}, 32'(fifo_data_in), 32'd0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    endtask

    int         exp2 [21] = '{1, 2, 1, 2, 3, 3, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 0};
    int         exp3 [13] = '{3, 3, 1, 2, 1, 2, 3, 3, 1, 2, 1, 2, 3};
    logic       expv3 [13] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    logic [7:0] expd3 [13] = '{8'h00, 8'h00, 8'h80, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h82, 8'h83, 8'h00, 8'h00, 8'h00};

    initial begin
        logic [7:0] d0, d1, exp_data, next_byte;
        logic [7:0] popped [5];
        int         got;

        reset       = 1'b0;
        wr0_valid   = 1'b0;
        wr1_valid   = 1'b0;
        wr0_data    = 8'h00;
        wr1_data    = 8'h00;
        rd_ready    = 1'b0;
        ram_flush   = 1'b1;
        ram_preload = 1'b0;

        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        checkResetOutputs("init");
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 1, 0);

        $display("[TB] round-robin writers with burst-limited reads, no consumer");
        d0 = 8'h10;
        d1 = 8'hA0;
        for (int c = 0; c < 21; c++) begin
            applyStimulus(1, 1, d0, 1, d1, 0, 0, 0);
            exp_data = (exp2[c] == 1) ? d0 : d1;
            checkGrant($sformatf("t2_c%0d", c + 1), exp2[c], exp_data);
            checkOutput("t2_write_while_full", 32'(fifo_write & fifo_full), 32'd0);
            if (exp2[c] == 1) d0++;
            else if (exp2[c] == 2) d1++;
        end
        checkOutput("t2_full", 32'(fifo_full), 32'd1);
        checkOutput("t2_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("t2_rd_head", 32'(rd_data), 32'h10);

        $display("[TB] reset held mid-traffic");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, d0, 1, d1, 1, 1, 0);
            checkResetOutputs($sformatf("t1_rst%0d", c));
        end

        $display("[TB] first grant after reset, single byte read latency");
        applyStimulus(1, 1, 8'h5A, 1, 8'hB0, 0, 0, 0);
        checkGrant("t1_first", 1, 8'h5A);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkGrant("t5_read", 3, 8'h00);
        checkOutput("t5_rv_at_read", 32'(rd_valid), 32'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkGrant("t5_empty", 0, 8'h00);
        checkOutput("t5_rv_inflight", 32'(rd_valid), 32'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
        checkOutput("t5_rv", 32'(rd_valid), 32'd1);
        checkOutput("t5_rd_data", 32'(rd_data), 32'h5A);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkOutput("t5_rv_after_pop", 32'(rd_valid), 32'd0);

        $display("[TB] reset while a read is in flight");
        applyStimulus(1, 0, 8'h00, 1, 8'h66, 0, 0, 0);
        checkGrant("t6_write", 2, 8'h66);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkGrant("t6_read", 3, 8'h00);
        applyStimulus(0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
        checkResetOutputs("t6_rst");
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
        checkOutput("t6_rv_post1", 32'(rd_valid), 32'd0);
        applyStimulus(1, 0, 8'h00, 0, 8'h00, 1, 0, 0);
        checkOutput("t6_rv_post2", 32'(rd_valid), 32'd0);
        checkOutput("t6_no_read", 32'(fifo_read), 32'd0);

        $display("[TB] ordered delivery with a stuttering consumer");
        next_byte = 8'h01;
        got       = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            applyStimulus(1, next_byte <= 8'h05, next_byte, 0, 8'h00, (c % 2) == 0, 0, 0);
            if (wr0_ready) next_byte++;
            if (rd_valid && rd_ready) begin
                popped[got] = rd_data;
                got++;
            end
            checkOutput("t4_rd_and_wr", 32'(fifo_read & fifo_write), 32'd0);
            checkOutput("t4_buf_le2", 32'(dut.u_outbuf.count_q <= 2'd2), 32'd1);
        end
        checkOutput("t4_pop_count", 32'(got), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t4_byte%0d", i), 32'(popped[i]), 32'(i + 1));
        end

        $display("[TB] burst alternation with preloaded RAM");
        d0 = 8'h40;
        d1 = 8'hC0;
        applyStimulus(0, 1, d0, 1, d1, 1, 1, 1);
        for (int c = 0; c < 13; c++) begin
            applyStimulus(1, 1, d0, 1, d1, 1, 0, 0);
            exp_data = (exp3[c] == 1) ? d0 : d1;
            checkGrant($sformatf("t3_c%0d", c + 1), exp3[c], exp_data);
            checkOutput($sformatf("t3_rv_c%0d", c + 1), 32'(rd_valid), 32'(expv3[c]));
            if (expv3[c]) begin
                checkOutput($sformatf("t3_rd_c%0d", c + 1), 32'(rd_data), 32'(expd3[c]));
            end
            if (exp3[c] == 1) d0++;
            else if (exp3[c] == 2) d1++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
